// File: rtl/apb_slv_pkg.sv
// Shared types and default sizes for the APB completer memory.
// Defaults track the master bridge's address/data widths.
package apb_slv_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam int APB_AW    = 9;
  localparam int APB_DW    = 8;
  localparam int APB_DEPTH = 64;

endpackage

// File: rtl/apb_slv_regfile.sv
// DEPTH x DATA_WIDTH register array, cleared by asynchronous reset.
// One synchronous write port and one combinational read port.
module apb_slv_regfile #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 64,
  parameter int IDX_W      = 6
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  we,
  input  logic [IDX_W-1:0]      waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [IDX_W-1:0]      raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/apb_slave_mem.sv
// APB3 completer fronting a word-addressed register memory.
// Define APB_SLV_WAIT_EN to insert WAIT_CYCLES wait states per transfer.
module apb_slave_mem
  import apb_slv_pkg::*;
#(
  parameter int ADDR_WIDTH  = APB_AW,
  parameter int DATA_WIDTH  = APB_DW,
  parameter int DEPTH       = APB_DEPTH,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr
);

  localparam int          IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] DEPTH_L = DEPTH;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  wr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  setup;
  logic                  in_range;
  logic                  in_range_q;
  logic                  we;

  assign setup      = (state == IDLE) && psel && !penable;
  assign in_range   = 32'(paddr) < DEPTH_L;
  assign in_range_q = 32'(addr_q) < DEPTH_L;

`ifdef APB_SLV_WAIT_EN
  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  logic [CNT_W-1:0] cnt;
  assign pready = (state == ACCESS) && (cnt == '0);
`else
  logic unused_wait_cfg;
  assign unused_wait_cfg = (WAIT_CYCLES != 0);
  assign pready = (state == ACCESS);
`endif

  assign pslverr = pready && !in_range_q;
  assign we      = (state == ACCESS) && psel && penable && pready && wr_q && in_range_q;

  // Control: FSM, wait counter and registered read data
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state  <= IDLE;
      prdata <= '0;
`ifdef APB_SLV_WAIT_EN
      cnt    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (setup) begin
            state  <= ACCESS;
            prdata <= (!pwrite && in_range) ? rd_word : '0;
`ifdef APB_SLV_WAIT_EN
            cnt    <= CNT_W'(WAIT_CYCLES);
`endif
          end
        end
        ACCESS: begin
          if (!psel) begin
            state <= IDLE;
          end else if (penable) begin
`ifdef APB_SLV_WAIT_EN
            if (cnt != '0) cnt <= cnt - 1'b1;
            else           state <= IDLE;
`else
            state <= IDLE;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Data: transfer attributes captured at setup, held through ACCESS
  always_ff @(posedge pclk) begin
    if (setup) begin
      addr_q  <= paddr;
      wr_q    <= pwrite;
      wdata_q <= pwdata;
    end
  end

  apb_slv_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .IDX_W      (IDX_W)
  ) u_regfile (
    .pclk   (pclk),
    .preset (preset),
    .we     (we),
    .waddr  (addr_q[IDX_W-1:0]),
    .wdata  (wdata_q),
    .raddr  (paddr[IDX_W-1:0]),
    .rdata  (rd_word)
  );

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench for apb_slave_mem; expected wait count follows APB_SLV_WAIT_EN.
module tb_apb_slave_mem;

  localparam int AW = 9;
  localparam int DW = 8;
  localparam int WC = 2;
`ifdef APB_SLV_WAIT_EN
  localparam int EXP_WAITS = WC;
`else
  localparam int EXP_WAITS = 0;
`endif

  logic          pclk = 1'b0;
  logic          preset;
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata;
  logic          pready;
  logic          pslverr;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 pclk = ~pclk;

  apb_slave_mem #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .DEPTH       (64),
    .WAIT_CYCLES (WC)
  ) dut (
    .pclk    (pclk),
    .preset  (preset),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .prdata  (prdata),
    .pready  (pready),
    .pslverr (pslverr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One complete APB transfer starting from posedge+1; returns at posedge+1 after completion.
  task automatic xfer(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      output logic [DW-1:0] rd, output logic err, output int waits);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    #1 chk("setup_pready", {31'b0, pready}, 32'd0);
    @(posedge pclk); #1;
    penable = 1'b1;
    paddr   = ~a;
    pwdata  = ~d;
    waits   = 0;
    while (pready !== 1'b1 && waits < 20) begin
      waits++;
      @(posedge pclk); #1;
    end
    if (pready !== 1'b1) chk("pready_timeout", {31'b0, pready}, 32'd1);
    rd  = prdata;
    err = pslverr;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  logic [DW-1:0] rd;
  logic          err;
  int            w;

  initial begin
    preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    repeat (2) @(posedge pclk);
    #1;
    chk("rst_pready",  {31'b0, pready},  32'd0);
    chk("rst_pslverr", {31'b0, pslverr}, 32'd0);
    chk("rst_prdata",  {24'b0, prdata},  32'd0);
    preset = 1'b0;
    @(posedge pclk); #1;

    // basic write then read
    xfer(1'b1, 9'h010, 8'hA5, rd, err, w);
    chk("wr10_err",   {31'b0, err}, 32'd0);
    chk("wr10_waits", w, EXP_WAITS);
    xfer(1'b0, 9'h010, 8'h00, rd, err, w);
    chk("rd10_data",  {24'b0, rd}, 32'hA5);
    chk("rd10_err",   {31'b0, err}, 32'd0);
    chk("rd10_waits", w, EXP_WAITS);

    // out-of-range accesses
    xfer(1'b1, 9'h040, 8'h3C, rd, err, w);
    chk("wr40_err", {31'b0, err}, 32'd1);
    xfer(1'b0, 9'h000, 8'h00, rd, err, w);
    chk("rd00_data", {24'b0, rd}, 32'h00);
    chk("rd00_err",  {31'b0, err}, 32'd0);
    xfer(1'b0, 9'h010, 8'h00, rd, err, w);
    chk("rd10_after_oor", {24'b0, rd}, 32'hA5);
    xfer(1'b0, 9'h1FF, 8'h00, rd, err, w);
    chk("rd1ff_data", {24'b0, rd}, 32'h00);
    chk("rd1ff_err",  {31'b0, err}, 32'd1);
    xfer(1'b0, 9'h03F, 8'h00, rd, err, w);
    chk("rd3f_err", {31'b0, err}, 32'd0);

    // back-to-back writes, no idle cycles
    xfer(1'b1, 9'h001, 8'h11, rd, err, w);
    xfer(1'b1, 9'h002, 8'h22, rd, err, w);
    xfer(1'b1, 9'h003, 8'h33, rd, err, w);
    chk("b2b_waits", w, EXP_WAITS);
    xfer(1'b0, 9'h001, 8'h00, rd, err, w);
    chk("b2b_rd1", {24'b0, rd}, 32'h11);
    xfer(1'b0, 9'h002, 8'h00, rd, err, w);
    chk("b2b_rd2", {24'b0, rd}, 32'h22);
    xfer(1'b0, 9'h003, 8'h00, rd, err, w);
    chk("b2b_rd3", {24'b0, rd}, 32'h33);
    chk("hold_prdata", {24'b0, prdata}, 32'h33);

    // access strobe without setup is ignored
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 9'h004; pwdata = 8'hEE;
    @(posedge pclk); #1;
    chk("nosetup_pready", {31'b0, pready}, 32'd0);
    psel = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;

    // abort: psel dropped in ACCESS
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 9'h005; pwdata = 8'h77;
    @(posedge pclk); #1;
    psel = 1'b0;
    @(posedge pclk); #1;
    chk("abort_pready", {31'b0, pready}, 32'd0);
    xfer(1'b0, 9'h005, 8'h00, rd, err, w);
    chk("abort_mem5",  {24'b0, rd}, 32'h00);
    chk("abort_waits", w, EXP_WAITS);

    // reset during the access phase of a write
    xfer(1'b0, 9'h010, 8'h00, rd, err, w);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 9'h006; pwdata = 8'h99;
    @(posedge pclk); #1;
    penable = 1'b1;
    #1 preset = 1'b1;
    #1;
    chk("midrst_pready",  {31'b0, pready},  32'd0);
    chk("midrst_pslverr", {31'b0, pslverr}, 32'd0);
    chk("midrst_prdata",  {24'b0, prdata},  32'd0);
    psel = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;
    preset = 1'b0;
    @(posedge pclk); #1;
    xfer(1'b0, 9'h006, 8'h00, rd, err, w);
    chk("postrst_mem6",  {24'b0, rd}, 32'h00);
    xfer(1'b0, 9'h010, 8'h00, rd, err, w);
    chk("postrst_mem10", {24'b0, rd}, 32'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
